// File: rtl/formula_fsm_pkg.sv
// Shared types and helpers for the sum-of-square-roots formula FSMs.
package formula_fsm_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } state_t;

   localparam int unsigned DEF_N_ARGS  = 3;
   localparam int unsigned DEF_N_UNITS = 2;
   localparam int unsigned DEF_W       = 32;

   function automatic int unsigned num_rounds(input int unsigned n_args,
                                              input int unsigned n_units);
      return (n_args + n_units - 1) / n_units;
   endfunction

   // Bits needed to hold any value in 0..n inclusive.
   function automatic int unsigned idx_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/isqrt_lane_sum.sv
// Combinational sum of the isqrt responses that land on pending lanes this cycle.
module isqrt_lane_sum #(
   parameter int unsigned N_UNITS = 2,
   parameter int unsigned W       = 32
) (
   input  logic [N_UNITS-1:0]       y_vld,
   input  logic [N_UNITS-1:0]       pending,
   input  logic [N_UNITS*(W/2)-1:0] y,
   output logic [W-1:0]             sum
);

   localparam int unsigned HW = W / 2;

   always_comb begin
      sum = '0;
      for (int unsigned l = 0; l < N_UNITS; l++) begin
         if (y_vld[l] && pending[l]) begin
            sum = sum + {{(W - HW){1'b0}}, y[l*HW +: HW]};
         end
      end
   end

endmodule

// File: rtl/formula_sum_isqrt_fsm.sv
// Sums isqrt(arg[i]) over N_ARGS arguments by issuing rounds of N_UNITS requests to
// external isqrt units and collecting each lane's response independently.
module formula_sum_isqrt_fsm
   import formula_fsm_pkg::*;
#(
   parameter int unsigned N_ARGS  = DEF_N_ARGS,
   parameter int unsigned N_UNITS = DEF_N_UNITS,
   parameter int unsigned W       = DEF_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arg_vld,
   input  logic [N_ARGS*W-1:0]        arg,
   output logic                       busy,
   output logic                       res_vld,
   output logic [W-1:0]               res,
   output logic [N_UNITS-1:0]         isqrt_x_vld,
   output logic [N_UNITS*W-1:0]       isqrt_x,
   input  logic [N_UNITS-1:0]         isqrt_y_vld,
   input  logic [N_UNITS*(W/2)-1:0]   isqrt_y
);

   localparam int unsigned ROUNDS = num_rounds(N_ARGS, N_UNITS);
   localparam int unsigned IDX_W  = idx_width(ROUNDS * N_UNITS);

   if (N_ARGS < 1 || N_UNITS < 1 || W < 2 || (W % 2) != 0) begin : g_bad_param
      $error("formula_sum_isqrt_fsm: N_ARGS and N_UNITS must be >= 1 and W even");
   end
   // Each root is below 2^(W/2), so more than 2^(W/2) of them could wrap the sum.
   if (64'(N_ARGS) > (64'd1 << (W / 2))) begin : g_overflow
      $error("formula_sum_isqrt_fsm: N_ARGS too large for a W-bit accumulator");
   end

   state_t                 state_q, state_d;
   logic [N_ARGS*W-1:0]    arg_q, arg_d;
   logic [IDX_W-1:0]       base_q, base_d;
   logic [N_UNITS-1:0]     pending_q, pending_d;
   logic [W-1:0]           acc_q, acc_d;
   logic [W-1:0]           lane_sum;

   logic                   busy_d, res_vld_d;
   logic [W-1:0]           res_d;
   logic [N_UNITS-1:0]     x_vld_d;
   logic [N_UNITS*W-1:0]   x_d;

   logic                   issue;
   logic [IDX_W-1:0]       issue_base;
   logic [N_ARGS*W-1:0]    issue_src;
   int unsigned            lane_idx;

   isqrt_lane_sum #(
      .N_UNITS (N_UNITS),
      .W       (W)
   ) u_lane_sum (
      .y_vld   (isqrt_y_vld),
      .pending (pending_q),
      .y       (isqrt_y),
      .sum     (lane_sum)
   );

   always_comb begin
      state_d    = state_q;
      arg_d      = arg_q;
      base_d     = base_q;
      pending_d  = pending_q;
      acc_d      = acc_q;
      busy_d     = busy;
      res_vld_d  = 1'b0;
      res_d      = res;
      issue      = 1'b0;
      issue_base = base_q;
      issue_src  = arg_q;
      x_vld_d    = '0;
      x_d        = isqrt_x;
      lane_idx   = 0;

      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (arg_vld) begin
               // Issue straight from the input so round 0 starts on the acceptance edge.
               arg_d      = arg;
               acc_d      = '0;
               base_d     = '0;
               busy_d     = 1'b1;
               issue      = 1'b1;
               issue_base = '0;
               issue_src  = arg;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            pending_d = pending_q & ~isqrt_y_vld;
            acc_d     = acc_q + lane_sum;
            if (pending_d == '0) begin
               if (32'(base_q) + N_UNITS >= N_ARGS) begin
                  state_d = StDone;
               end else begin
                  base_d     = base_q + IDX_W'(N_UNITS);
                  issue      = 1'b1;
                  issue_base = base_d;
                  state_d    = StIssue;
               end
            end
         end
         StDone: begin
            res_d     = acc_q;
            res_vld_d = 1'b1;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue) begin
         for (int unsigned l = 0; l < N_UNITS; l++) begin
            lane_idx          = 32'(issue_base) + l;
            x_d[l*W +: W]     = '0;
            if (lane_idx < N_ARGS) begin
               x_vld_d[l]   = 1'b1;
               pending_d[l] = 1'b1;
               for (int unsigned a = 0; a < N_ARGS; a++) begin
                  if (lane_idx == a) begin
                     x_d[l*W +: W] = issue_src[a*W +: W];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         arg_q       <= '0;
         base_q      <= '0;
         pending_q   <= '0;
         acc_q       <= '0;
         busy        <= 1'b0;
         res_vld     <= 1'b0;
         res         <= '0;
         isqrt_x_vld <= '0;
         isqrt_x     <= '0;
      end else begin
         state_q     <= state_d;
         arg_q       <= arg_d;
         base_q      <= base_d;
         pending_q   <= pending_d;
         acc_q       <= acc_d;
         busy        <= busy_d;
         res_vld     <= res_vld_d;
         res         <= res_d;
         isqrt_x_vld <= x_vld_d;
         isqrt_x     <= x_d;
      end
   end

endmodule

// File: tb/tb_formula_sum_isqrt_fsm.sv
// Directed bench: 3-arg/2-unit instance with a modelled isqrt bank, plus a 3-arg/4-unit instance.
module tb_formula_sum_isqrt_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        arg_vld;
   logic [95:0] arg;
   logic        busy, res_vld;
   logic [31:0] res;
   logic [1:0]  x_vld;
   logic [63:0] x;
   logic [1:0]  y_vld;
   logic [31:0] y;

   logic         arg_vld4;
   logic [95:0]  arg4;
   logic         busy4, res_vld4;
   logic [31:0]  res4;
   logic [3:0]   x_vld4;
   logic [127:0] x4;
   logic [3:0]   y_vld4;
   logic [63:0]  y4;

   logic [1:0]  resp_vld;
   logic [15:0] resp_y [2];
   int          lat [2];
   int          hold [2];
   int          cnt [2];
   int          hold_left [2];
   logic [31:0] rad [2];

   int total = 0;
   int bad   = 0;

   assign y_vld = resp_vld;
   assign y     = {resp_y[1], resp_y[0]};

   formula_sum_isqrt_fsm #(.N_ARGS(3), .N_UNITS(2), .W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .arg_vld     (arg_vld),
      .arg         (arg),
      .busy        (busy),
      .res_vld     (res_vld),
      .res         (res),
      .isqrt_x_vld (x_vld),
      .isqrt_x     (x),
      .isqrt_y_vld (y_vld),
      .isqrt_y     (y)
   );

   formula_sum_isqrt_fsm #(.N_ARGS(3), .N_UNITS(4), .W(32)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .arg_vld     (arg_vld4),
      .arg         (arg4),
      .busy        (busy4),
      .res_vld     (res_vld4),
      .res         (res4),
      .isqrt_x_vld (x_vld4),
      .isqrt_x     (x4),
      .isqrt_y_vld (y_vld4),
      .isqrt_y     (y4)
   );

   function automatic logic [15:0] isqrt32(input logic [31:0] v);
      logic [63:0] r;
      logic [63:0] t;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= {32'd0, v}) r = t;
      end
      return r[15:0];
   endfunction

   // isqrt bank model: lane L answers lat[L] cycles after its request, strobe held hold[L] cycles.
   initial begin
      resp_vld = '0;
      for (int l = 0; l < 2; l++) begin
         resp_y[l] = '0; cnt[l] = 0; hold_left[l] = 0; rad[l] = '0;
         lat[l] = 2; hold[l] = 1;
      end
      forever begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            if (hold_left[l] > 0) hold_left[l]--;
            if (hold_left[l] == 0) resp_vld[l] = 1'b0;
            if (cnt[l] > 0) begin
               cnt[l]--;
               if (cnt[l] == 0) begin
                  resp_vld[l]  = 1'b1;
                  resp_y[l]    = isqrt32(rad[l]);
                  hold_left[l] = hold[l];
               end
            end
            if (x_vld[l]) begin
               cnt[l] = lat[l];
               rad[l] = x[l*32 +: 32];
            end
         end
      end
   end

   task automatic wait_res(input int max_cyc, output bit got, output logic [31:0] r,
                           output int cyc);
      got = 1'b0; r = '0; cyc = 0;
      for (int k = 1; k <= max_cyc && !got; k++) begin
         @(negedge clk);
         arg_vld = 1'b0;
         if (res_vld === 1'b1) begin
            got = 1'b1; r = res; cyc = k;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL reset_res_vld got=%b want=0", res_vld); end
      total++; if (res !== 32'd0) begin bad++; $display("FAIL reset_res got=%0d want=0", res); end
      total++; if (x_vld !== 2'b00) begin bad++; $display("FAIL reset_x_vld got=%b want=00", x_vld); end
      total++; if (x !== 64'd0) begin bad++; $display("FAIL reset_x got=%h want=0", x); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [1:0] exp_xv;
      arg = {32'd9, 32'd4, 32'd1};
      arg_vld = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         arg_vld = 1'b0;
         exp_xv = (k == 1) ? 2'b11 : (k == 4) ? 2'b01 : 2'b00;
         total++;
         if (busy !== (k <= 8)) begin
            bad++; $display("FAIL basic_busy cyc=%0d got=%b want=%b", k, busy, (k <= 8));
         end
         total++;
         if (res_vld !== (k == 8)) begin
            bad++; $display("FAIL basic_res_vld cyc=%0d got=%b want=%b", k, res_vld, (k == 8));
         end
         total++;
         if (x_vld !== exp_xv) begin
            bad++; $display("FAIL basic_x_vld cyc=%0d got=%b want=%b", k, x_vld, exp_xv);
         end
         if (k == 1) begin
            total++;
            if (x !== {32'd4, 32'd1}) begin bad++; $display("FAIL basic_x_r1 got=%h want=%h", x, {32'd4, 32'd1}); end
         end
         if (k == 4) begin
            total++;
            if (x !== {32'd0, 32'd9}) begin bad++; $display("FAIL basic_x_r2 got=%h want=%h", x, {32'd0, 32'd9}); end
         end
         if (k == 8) begin
            total++;
            if (res !== 32'd6) begin bad++; $display("FAIL basic_res got=%0d want=6", res); end
         end
      end
   endtask

   task automatic test_skew();
      bit got; logic [31:0] r; int cyc;
      lat[0] = 5; lat[1] = 2; hold[1] = 2;
      @(negedge clk);
      arg = {32'd36, 32'd25, 32'd16};
      arg_vld = 1'b1;
      wait_res(40, got, r, cyc);
      total++;
      if (!got || r !== 32'd15) begin bad++; $display("FAIL skew_res got_vld=%0d res=%0d want=15", got, r); end
      total++;
      if (cyc != 14) begin bad++; $display("FAIL skew_latency got=%0d want=14", cyc); end
      repeat (3) @(negedge clk);
      lat[0] = 2; lat[1] = 2; hold[1] = 1;
   endtask

   task automatic test_max();
      bit got; logic [31:0] r; int cyc;
      @(negedge clk);
      arg = {3{32'hFFFF_FFFF}};
      arg_vld = 1'b1;
      wait_res(20, got, r, cyc);
      total++;
      if (!got || r !== 32'd196605) begin bad++; $display("FAIL max_res got_vld=%0d res=%0d want=196605", got, r); end
      total++;
      if (cyc != 8) begin bad++; $display("FAIL max_latency got=%0d want=8", cyc); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ignore_arg_vld();
      int n_vld = 0;
      @(negedge clk);
      arg = {32'd9, 32'd4, 32'd1};
      arg_vld = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         arg_vld = 1'b0;
         if (k == 2) begin
            arg = {3{32'd100}};
            arg_vld = 1'b1;
         end
         if (res_vld === 1'b1) begin
            n_vld++;
            total++;
            if (k != 8 || res !== 32'd6) begin
               bad++; $display("FAIL ignore_res cyc=%0d res=%0d want cyc=8 res=6", k, res);
            end
         end
      end
      total++;
      if (n_vld != 1) begin bad++; $display("FAIL ignore_res_vld_count got=%0d want=1", n_vld); end
   endtask

   task automatic test_reset_mid();
      bit got; logic [31:0] r; int cyc;
      @(negedge clk);
      arg = {32'd36, 32'd25, 32'd16};
      arg_vld = 1'b1;
      @(negedge clk);
      arg_vld = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      total++; if (res !== 32'd0) begin bad++; $display("FAIL rstmid_res got=%0d want=0", res); end
      total++; if (x !== 64'd0) begin bad++; $display("FAIL rstmid_x got=%h want=0", x); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || res_vld !== 1'b0 || x_vld !== 2'b00) begin
            bad++; $display("FAIL rstmid_idle k=%0d busy=%b res_vld=%b x_vld=%b want 0/0/00",
                            k, busy, res_vld, x_vld);
         end
      end
      arg = {32'd0, 32'd1, 32'd0};
      arg_vld = 1'b1;
      wait_res(20, got, r, cyc);
      total++;
      if (!got || r !== 32'd1) begin bad++; $display("FAIL rstmid_next_res got_vld=%0d res=%0d want=1", got, r); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_four_units();
      logic [3:0] exp_xv;
      @(negedge clk);
      arg4 = {32'd16, 32'd9, 32'd4};
      arg_vld4 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         arg_vld4 = 1'b0;
         y_vld4 = 4'b0000;
         exp_xv = (k == 1) ? 4'b0111 : 4'b0000;
         total++;
         if (x_vld4 !== exp_xv) begin
            bad++; $display("FAIL four_x_vld cyc=%0d got=%b want=%b", k, x_vld4, exp_xv);
         end
         total++;
         if (res_vld4 !== (k == 4)) begin
            bad++; $display("FAIL four_res_vld cyc=%0d got=%b want=%b", k, res_vld4, (k == 4));
         end
         if (k == 1) begin
            total++;
            if (x4 !== {32'd0, 32'd16, 32'd9, 32'd4}) begin
               bad++; $display("FAIL four_x got=%h want=%h", x4, {32'd0, 32'd16, 32'd9, 32'd4});
            end
         end
         if (k == 2) begin
            // All lanes answer together; lane 3 was never issued.
            y_vld4 = 4'b1111;
            y4 = {16'd9, 16'd4, 16'd3, 16'd2};
         end
         if (k == 4) begin
            total++;
            if (res4 !== 32'd9) begin bad++; $display("FAIL four_res got=%0d want=9", res4); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; arg_vld = 1'b0; arg = '0;
      arg_vld4 = 1'b0; arg4 = '0; y_vld4 = '0; y4 = '0;
      test_reset();
      test_basic();
      test_skew();
      test_max();
      test_ignore_arg_vld();
      test_reset_mid();
      test_four_units();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
